// File: rtl/tri_128x168_arb.sv
// tri_128x168_arb: round-robin write/read arbiter and sequencer for the 128x168 single-port array.
// Define TRI_128X168_ARB_INIT_EN to zero every entry after reset before requests are accepted.
`default_nettype none

`ifndef NCLK_WIDTH
`define NCLK_WIDTH 1
`endif

// ============================================================================
// Module   : tri_128x168_arb
// Purpose  : Single-port array access arbiter, 1-cycle read return,
//            optional post-reset zero sweep (TRI_128X168_ARB_INIT_EN).
// Revision : 1.0
// ============================================================================
module tri_128x168_arb #(
  parameter int ADDRESSABLE_PORTS = 128,
  parameter int ADDRESSBUS_WIDTH  = 7,
  parameter int PORT_BITWIDTH     = 168
) (
  input  logic [`NCLK_WIDTH-1:0]     nclk,
  input  logic                       rst_b,
  input  logic                       wr_req,
  input  logic [ADDRESSBUS_WIDTH-1:0] wr_addr,
  input  logic [PORT_BITWIDTH-1:0]   wr_data,
  output logic                       wr_gnt,
  input  logic                       rd_req,
  input  logic [ADDRESSBUS_WIDTH-1:0] rd_addr,
  output logic                       rd_gnt,
  output logic                       rd_val,
  output logic [PORT_BITWIDTH-1:0]   rd_data,
  output logic                       ary_act,
  output logic                       ary_write_enable,
  output logic [ADDRESSBUS_WIDTH-1:0] ary_addr,
  output logic [PORT_BITWIDTH-1:0]   ary_data_in,
  input  logic [PORT_BITWIDTH-1:0]   ary_data_out,
  output logic                       init_busy
);

  logic clk;
  assign clk = nclk[0];

  logic                        init_active;
  logic [ADDRESSBUS_WIDTH-1:0] init_addr;

`ifdef TRI_128X168_ARB_INIT_EN
  localparam logic [ADDRESSBUS_WIDTH-1:0] C_LAST_ENTRY =
    ADDRESSBUS_WIDTH'(ADDRESSABLE_PORTS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDRESSBUS_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == C_LAST_ENTRY) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  assign init_active = (state_q == ST_INIT);
  assign init_addr   = cnt_q;
`else
  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  assign init_busy = init_active;

  logic                        last_wr_q, last_wr_d;
  logic [ADDRESSBUS_WIDTH-1:0] addr_q, addr_d;
  logic                        rd_val_q;

  // Grants are gated by rst_b so every output sits at its reset value while reset is held.
  always_comb begin
    wr_gnt           = 1'b0;
    rd_gnt           = 1'b0;
    ary_act          = 1'b0;
    ary_write_enable = 1'b0;
    ary_addr         = addr_q;
    ary_data_in      = '0;
    if (!rst_b) begin
      ary_addr = addr_q;
    end else if (init_active) begin
      ary_act          = 1'b1;
      ary_write_enable = 1'b1;
      ary_addr         = init_addr;
    end else begin
      if (wr_req && (!rd_req || !last_wr_q)) begin
        wr_gnt = 1'b1;
      end else if (rd_req) begin
        rd_gnt = 1'b1;
      end
      if (wr_gnt) begin
        ary_act          = 1'b1;
        ary_write_enable = 1'b1;
        ary_addr         = wr_addr;
        ary_data_in      = wr_data;
      end else if (rd_gnt) begin
        ary_act  = 1'b1;
        ary_addr = rd_addr;
      end
    end
  end

  always_comb begin
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    if (wr_gnt || rd_gnt) begin
      last_wr_d = wr_gnt;
    end
    if (ary_act) begin
      addr_d = ary_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      rd_val_q  <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      rd_val_q  <= rd_gnt;
    end
  end

  assign rd_val  = rd_val_q;
  assign rd_data = rd_val_q ? ary_data_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_tri_128x168_arb.sv
// tb_tri_128x168_arb: directed self-checking bench for tri_128x168_arb with a behavioural array model.
`default_nettype none

module tb_tri_128x168_arb;

`ifdef TRI_128X168_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic [`NCLK_WIDTH-1:0] nclk;
  logic         rst_b;
  logic         wr_req, rd_req;
  logic [6:0]   wr_addr, rd_addr;
  logic [167:0] wr_data;
  logic         wr_gnt, rd_gnt, rd_val;
  logic [167:0] rd_data;
  logic         ary_act, ary_write_enable;
  logic [6:0]   ary_addr;
  logic [167:0] ary_data_in, ary_data_out;
  logic         init_busy;

  int checks = 0;
  int errors = 0;

  logic [167:0] mem [128];
  logic [167:0] pat_a5, pat_p;

  tri_128x168_arb dut (
    .nclk(nclk), .rst_b(rst_b),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_val(rd_val), .rd_data(rd_data),
    .ary_act(ary_act), .ary_write_enable(ary_write_enable),
    .ary_addr(ary_addr), .ary_data_in(ary_data_in), .ary_data_out(ary_data_out),
    .init_busy(init_busy)
  );

  initial nclk = '0;
  always #5 nclk[0] = ~nclk[0];

  // Synchronous single-port array with 1-cycle read latency
  initial ary_data_out = '0;
  always @(posedge nclk[0]) begin
    if (ary_act) begin
      if (ary_write_enable) mem[ary_addr] <= ary_data_in;
      else                  ary_data_out  <= mem[ary_addr];
    end
  end

  task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge nclk[0]);
  endtask

  initial begin
    pat_a5  = {21{8'hA5}};
    pat_p   = {42{4'h3}} ^ {168'h1234_5678_9ABC_DEF0};
    rst_b   = 1'b0;
    wr_req  = 1'b0; rd_req = 1'b0;
    wr_addr = '0;   rd_addr = '0;
    wr_data = '0;

    // Reset values, then requests held during reset must stay ungranted
    repeat (2) cyc();
    #1;
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_rd_val", rd_val, 0);
    chk("rst_act", ary_act, 0);
    chk("rst_we", ary_write_enable, 0);
    chk("rst_addr", ary_addr, 0);
    chk("rst_din", ary_data_in, 0);
    chk("rst_init_busy", init_busy, INIT_EN);
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 7'd10; wr_data = pat_p; rd_addr = 7'd127;
    #1;
    chk("rst_held_wr_gnt", wr_gnt, 0);
    chk("rst_held_rd_gnt", rd_gnt, 0);

    cyc();
    rst_b = 1'b1;
    if (INIT_EN) begin
      for (int i = 0; i < 128; i++) begin
        if (i > 0) cyc();
        #1;
        chk("init_busy", init_busy, 1);
        chk("init_addr", ary_addr, i);
        chk("init_we", ary_write_enable, 1);
        chk("init_act", ary_act, 1);
        chk("init_din", ary_data_in, 0);
        chk("init_wr_gnt", wr_gnt, 0);
        chk("init_rd_gnt", rd_gnt, 0);
      end
      cyc(); #1;
      chk("post_init_busy", init_busy, 0);
      chk("first_grant_wr", wr_gnt, 1);
      chk("first_grant_rd", rd_gnt, 0);
      chk("first_grant_addr", ary_addr, 10);
      cyc(); #1;
      chk("second_grant_rd", rd_gnt, 1);
      chk("second_grant_addr", ary_addr, 127);
      cyc();
      wr_req = 1'b0; rd_req = 1'b0;
      #1;
      chk("rd127_val", rd_val, 1);
      chk("rd127_zero", rd_data, 0);
    end else begin
      wr_req = 1'b0; rd_addr = 7'd3;
      #1;
      chk("norst_init_busy", init_busy, 0);
      chk("first_rd_gnt", rd_gnt, 1);
      chk("first_rd_wr_gnt", wr_gnt, 0);
      chk("first_rd_act", ary_act, 1);
      chk("first_rd_addr", ary_addr, 3);
      cyc();
      rd_req = 1'b0;
      #1;
      chk("first_rd_val", rd_val, 1);
    end

    // Write 5 then read 5 on the next cycle
    cyc();
    wr_req = 1'b1; wr_addr = 7'd5; wr_data = pat_a5;
    #1;
    chk("w5_gnt", wr_gnt, 1);
    chk("w5_we", ary_write_enable, 1);
    chk("w5_addr", ary_addr, 5);
    chk("w5_din", ary_data_in, pat_a5);
    cyc();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 7'd5;
    #1;
    chk("r5_gnt", rd_gnt, 1);
    chk("r5_we", ary_write_enable, 0);
    chk("r5_din", ary_data_in, 0);
    chk("r5_val_early", rd_val, 0);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("r5_val", rd_val, 1);
    chk("r5_data", rd_data, pat_a5);
    chk("idle_act", ary_act, 0);
    chk("idle_addr_hold", ary_addr, 5);
    cyc(); #1;
    chk("idle_val", rd_val, 0);
    chk("idle_data", rd_data, 0);

    // Continuous dual requests alternate W,R,W,R starting with W
    cyc();
    wr_req = 1'b1; wr_addr = 7'd9; wr_data = pat_p;
    rd_req = 1'b1; rd_addr = 7'd5;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      #1;
      chk("alt_wr", wr_gnt, (i % 2) == 0);
      chk("alt_rd", rd_gnt, (i % 2) == 1);
      chk("alt_val", rd_val, (i > 0) && ((i % 2) == 0));
      if ((i > 0) && ((i % 2) == 0)) chk("alt_data", rd_data, pat_a5);
    end
    cyc();
    wr_req = 1'b0; rd_req = 1'b0;
    #1;
    chk("alt_tail_val", rd_val, 1);
    chk("alt_tail_data", rd_data, pat_a5);

    // Back-to-back reads: 9 then 5
    cyc();
    rd_req = 1'b1; rd_addr = 7'd9;
    #1;
    chk("b2b_gnt0", rd_gnt, 1);
    cyc();
    rd_addr = 7'd5;
    #1;
    chk("b2b_gnt1", rd_gnt, 1);
    chk("b2b_val0", rd_val, 1);
    chk("b2b_data0", rd_data, pat_p);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("b2b_val1", rd_val, 1);
    chk("b2b_data1", rd_data, pat_a5);

    // Reset arrives at the edge that would register a read grant
    cyc();
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 7'd5;
    #1;
    chk("pre_rst_rd_gnt", rd_gnt, 0);
    chk("pre_rst_wr_gnt", wr_gnt, 1);
    cyc();
    #1;
    chk("pre_rst_rd_gnt2", rd_gnt, 1);
    #1;
    rst_b = 1'b0;
    cyc(); #1;
    chk("mid_rst_val", rd_val, 0);
    chk("mid_rst_rd_gnt", rd_gnt, 0);
    chk("mid_rst_wr_gnt", wr_gnt, 0);
    chk("mid_rst_act", ary_act, 0);
    chk("mid_rst_addr", ary_addr, 0);
    chk("mid_rst_busy", init_busy, INIT_EN);
    cyc();
    rst_b = 1'b1; wr_req = 1'b0;
    #1;
    if (INIT_EN) begin
      chk("reinit_busy", init_busy, 1);
      chk("reinit_addr0", ary_addr, 0);
      chk("reinit_rd_gnt", rd_gnt, 0);
      cyc(); #1;
      chk("reinit_addr1", ary_addr, 1);
    end else begin
      chk("rerun_rd_gnt", rd_gnt, 1);
      chk("rerun_addr", ary_addr, 5);
      cyc();
      rd_req = 1'b0;
      #1;
      chk("rerun_val", rd_val, 1);
      chk("rerun_data", rd_data, pat_a5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
